// File: rtl/jam_perm_engine.sv
// rtl/jam_perm_engine.sv - exhaustive N x N job-assignment search over all permutations in lexicographic order.
// Optional BestJ output (first minimum-cost permutation) enabled by defining BEST_PERM_EN.
module jam_perm_engine #(
  parameter  int N    = 8,
  parameter  int CW   = 7,
  parameter  int MCW  = 16,
  localparam int IDXW = $clog2(N),
  localparam int SUMW = CW + $clog2(N + 1)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  output logic            Req,
  output logic [IDXW-1:0] W,
  output logic [IDXW-1:0] J,
  input  logic [CW-1:0]   Cost,
  input  logic            Cost_vld,
  output logic            Busy,
  output logic            Valid,
  output logic [SUMW-1:0] MinCost,
  output logic [MCW-1:0]  MatchCount
`ifdef BEST_PERM_EN
  ,output logic [N*IDXW-1:0] BestJ
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EVAL, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [IDXW-1:0] r_perm [N];
  logic [IDXW-1:0] w_next_perm [N];
  logic [IDXW-1:0] r_w;
  logic [SUMW-1:0] r_sum;
  logic [SUMW-1:0] r_min;
  logic [MCW-1:0]  r_match;
  logic            w_has_pivot;
  logic            w_last_w;
  int              w_piv;
  int              w_swp;
  int              w_src;
`ifdef BEST_PERM_EN
  logic [IDXW-1:0] r_best [N];
`endif

  assign w_last_w   = (r_w == IDXW'(N - 1));
  assign Req        = (r_state == S_FETCH);
  assign Busy       = (r_state != S_IDLE);
  assign Valid      = (r_state == S_DONE);
  assign W          = r_w;
  assign J          = r_perm[r_w];
  assign MinCost    = r_min;
  assign MatchCount = r_match;

`ifdef BEST_PERM_EN
  always_comb begin
    BestJ = '0;
    for (int k = 0; k < N; k++) BestJ[k*IDXW +: IDXW] = r_best[k];
  end
`endif

  // Lexicographic successor: swap pivot with its rightmost larger element, then reverse the tail.
  always_comb begin
    w_has_pivot = 1'b0;
    w_piv       = 0;
    w_swp       = 0;
    w_src       = 0;
    for (int k = 0; k < N - 1; k++) begin
      if (r_perm[k] < r_perm[k+1]) begin
        w_piv       = k;
        w_has_pivot = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (k > w_piv && r_perm[k] > r_perm[w_piv]) w_swp = k;
    end
    for (int k = 0; k < N; k++) begin
      w_next_perm[k] = r_perm[k];
      if (k == w_piv) begin
        w_next_perm[k] = r_perm[w_swp];
      end else if (k > w_piv) begin
        w_src = N + w_piv - k;
        w_next_perm[k] = (w_src == w_swp) ? r_perm[w_piv] : r_perm[w_src];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_next_state = S_FETCH;
      S_FETCH: if (Cost_vld && w_last_w) w_next_state = S_EVAL;
      S_EVAL:  w_next_state = w_has_pivot ? S_FETCH : S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_w     <= '0;
      r_sum   <= '0;
      r_min   <= '1;
      r_match <= '0;
      for (int k = 0; k < N; k++) r_perm[k] <= IDXW'(k);
`ifdef BEST_PERM_EN
      for (int k = 0; k < N; k++) r_best[k] <= IDXW'(k);
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_w     <= '0;
            r_sum   <= '0;
            r_min   <= '1;
            r_match <= '0;
            for (int k = 0; k < N; k++) r_perm[k] <= IDXW'(k);
`ifdef BEST_PERM_EN
            for (int k = 0; k < N; k++) r_best[k] <= IDXW'(k);
`endif
          end
        end
        S_FETCH: begin
          if (Cost_vld) begin
            r_sum <= r_sum + {{(SUMW-CW){1'b0}}, Cost};
            if (!w_last_w) r_w <= r_w + 1'b1;
          end
        end
        S_EVAL: begin
          if (r_sum < r_min) begin
            r_min   <= r_sum;
            r_match <= {{(MCW-1){1'b0}}, 1'b1};
`ifdef BEST_PERM_EN
            for (int k = 0; k < N; k++) r_best[k] <= r_perm[k];
`endif
          end else if (r_sum == r_min && r_match != {MCW{1'b1}}) begin
            r_match <= r_match + 1'b1;
          end
          if (w_has_pivot) begin
            for (int k = 0; k < N; k++) r_perm[k] <= w_next_perm[k];
            r_w   <= '0;
            r_sum <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_perm_engine.sv
// tb/tb_jam_perm_engine.sv - directed bench for jam_perm_engine (three parameter sets, shared clock/reset).
module tb_jam_perm_engine;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic start;
  int   sel;
  int   mode;
  logic delay_en;

  // Instance A: N=4, CW=7, MCW=16
  logic       req_a, vld_a, busy_a, valid_a;
  logic [1:0] w_a, j_a;
  logic [6:0] cost_a;
  logic [9:0] min_a;
  logic [15:0] cnt_a;
  int         wcnt;
`ifdef BEST_PERM_EN
  logic [7:0] best_a;
`endif

  // Instance B: N=4, CW=2, MCW=4
  logic       req_b, busy_b, valid_b;
  logic [1:0] w_b, j_b;
  logic [4:0] min_b;
  logic [3:0] cnt_b;
`ifdef BEST_PERM_EN
  logic [7:0] best_b;
`endif

  // Instance C: N=5, CW=7, MCW=16
  logic       req_c, busy_c, valid_c;
  logic [2:0] w_c, j_c;
  logic [9:0] min_c;
  logic [15:0] cnt_c;
`ifdef BEST_PERM_EN
  logic [14:0] best_c;
`endif

  logic vsel;

  assign cost_a = (mode == 0) ? 7'd1 : ((({1'b0, w_a} + {1'b0, j_a}) == 3'd3) ? 7'd0 : 7'd9);
  assign vld_a  = req_a && (!delay_en || wcnt == 0);
  assign vsel   = (sel == 0) ? valid_a : (sel == 1) ? valid_b : valid_c;

  always @(posedge CLK) begin
    if (RST) wcnt <= 0;
    else if (req_a) begin
      if (vld_a) wcnt <= delay_en ? int'($urandom_range(0, 5)) : 0;
      else       wcnt <= wcnt - 1;
    end
  end

  jam_perm_engine #(.N(4), .CW(7), .MCW(16)) u_a (
    .CLK(CLK), .RST(RST), .Start(start && sel == 0), .Req(req_a), .W(w_a), .J(j_a),
    .Cost(cost_a), .Cost_vld(vld_a), .Busy(busy_a), .Valid(valid_a),
    .MinCost(min_a), .MatchCount(cnt_a)
`ifdef BEST_PERM_EN
    , .BestJ(best_a)
`endif
  );

  jam_perm_engine #(.N(4), .CW(2), .MCW(4)) u_b (
    .CLK(CLK), .RST(RST), .Start(start && sel == 1), .Req(req_b), .W(w_b), .J(j_b),
    .Cost(2'd3), .Cost_vld(req_b), .Busy(busy_b), .Valid(valid_b),
    .MinCost(min_b), .MatchCount(cnt_b)
`ifdef BEST_PERM_EN
    , .BestJ(best_b)
`endif
  );

  jam_perm_engine #(.N(5), .CW(7), .MCW(16)) u_c (
    .CLK(CLK), .RST(RST), .Start(start && sel == 2), .Req(req_c), .W(w_c), .J(j_c),
    .Cost({4'b0, j_c}), .Cost_vld(1'b1), .Busy(busy_c), .Valid(valid_c),
    .MinCost(min_c), .MatchCount(cnt_c)
`ifdef BEST_PERM_EN
    , .BestJ(best_c)
`endif
  );

  // W/J must not move while a request is outstanding.
  logic       prev_pending = 1'b0;
  logic [1:0] pw, pj;
  int         stab_checks = 0;
  int         stab_bad = 0;
  always @(negedge CLK) begin
    if (prev_pending) begin
      stab_checks <= stab_checks + 1;
      if (w_a !== pw || j_a !== pj) stab_bad <= stab_bad + 1;
    end
    prev_pending <= delay_en && !RST && req_a && !vld_a;
    pw <= w_a;
    pj <= j_a;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse Start for one accepted edge, return edges counted to the Valid cycle (inclusive), or -1.
  task automatic run(input int s, input int budget, input int pulse_at, output int cycles);
    @(negedge CLK);
    sel   = s;
    start = 1'b1;
    @(negedge CLK);
    start  = 1'b0;
    cycles = 1;
    while (!vsel && cycles < budget) begin
      start = (cycles == pulse_at);
      @(negedge CLK);
      cycles++;
    end
    start = 1'b0;
    if (!vsel) cycles = -1;
  endtask

  int cyc;
  int vseen;
  int bseen;

  initial begin
    start    = 1'b0;
    sel      = 0;
    mode     = 0;
    delay_en = 1'b0;
    RST      = 1'b1;
    repeat (3) @(negedge CLK);

    check("rst_busy",  64'(busy_a),  64'd0);
    check("rst_req",   64'(req_a),   64'd0);
    check("rst_valid", 64'(valid_a), 64'd0);
    check("rst_w",     64'(w_a),     64'd0);
    check("rst_j",     64'(j_a),     64'd0);
    check("rst_min",   64'(min_a),   64'd1023);
    check("rst_cnt",   64'(cnt_a),   64'd0);
    check("rst_min_b", 64'(min_b),   64'd31);
`ifdef BEST_PERM_EN
    check("rst_best",  64'(best_a),  64'hE4);
`endif
    RST = 1'b0;
    @(negedge CLK);

    // T2: unique minimum on the anti-diagonal (last permutation)
    mode = 1;
    run(0, 500, 0, cyc);
    check("t2_lat", 64'(cyc),   64'd121);
    check("t2_min", 64'(min_a), 64'd0);
    check("t2_cnt", 64'(cnt_a), 64'd1);
`ifdef BEST_PERM_EN
    check("t2_best", 64'(best_a), 64'h1B);
`endif
    @(negedge CLK);
    check("t2_valid_pulse", 64'(valid_a), 64'd0);
    check("t2_idle_busy",   64'(busy_a),  64'd0);
    repeat (5) @(negedge CLK);
    check("t2_hold_min", 64'(min_a), 64'd0);
    check("t2_hold_cnt", 64'(cnt_a), 64'd1);

    // T1: all costs 1; Start must reinitialise results
    mode = 0;
    run(0, 500, 0, cyc);
    check("t1_lat", 64'(cyc),   64'd121);
    check("t1_min", 64'(min_a), 64'd4);
    check("t1_cnt", 64'(cnt_a), 64'd24);
`ifdef BEST_PERM_EN
    check("t1_best", 64'(best_a), 64'hE4);
`endif

    // T4: random 0..5 cycle cost latency
    delay_en = 1'b1;
    run(0, 5000, 0, cyc);
    check("t4_done",  64'(cyc > 0),         64'd1);
    check("t4_min",   64'(min_a),           64'd4);
    check("t4_cnt",   64'(cnt_a),           64'd24);
    check("t4_stab",  64'(stab_bad),        64'd0);
    check("t4_waits", 64'(stab_checks > 0), 64'd1);
    delay_en = 1'b0;
    @(negedge CLK);

    // T5: MatchCount saturates at 4 bits, costs at CW all-ones
    run(1, 500, 0, cyc);
    check("t5_lat", 64'(cyc),   64'd121);
    check("t5_min", 64'(min_b), 64'd12);
    check("t5_cnt", 64'(cnt_b), 64'd15);

    // T3 (scaled to N=5): Cost=J, Cost_vld tied high
    run(2, 2000, 0, cyc);
    check("t3_lat", 64'(cyc),   64'd721);
    check("t3_min", 64'(min_c), 64'd10);
    check("t3_cnt", 64'(cnt_c), 64'd120);

    // T6a: Start pulsed while Busy has no effect
    mode = 0;
    run(0, 500, 50, cyc);
    check("t6_ign_lat", 64'(cyc),   64'd121);
    check("t6_ign_min", 64'(min_a), 64'd4);
    check("t6_ign_cnt", 64'(cnt_a), 64'd24);

    // T6b: reset mid-FETCH aborts the run
    @(negedge CLK);
    sel   = 0;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (7) @(negedge CLK);
    check("t6_in_fetch", 64'(req_a), 64'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("t6_busy",  64'(busy_a),  64'd0);
    check("t6_req",   64'(req_a),   64'd0);
    check("t6_valid", 64'(valid_a), 64'd0);
    check("t6_w",     64'(w_a),     64'd0);
    check("t6_j",     64'(j_a),     64'd0);
    check("t6_min",   64'(min_a),   64'd1023);
    check("t6_cnt",   64'(cnt_a),   64'd0);
    vseen = 0;
    bseen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (valid_a) vseen++;
      if (busy_a)  bseen++;
    end
    check("t6_no_valid", 64'(vseen), 64'd0);
    check("t6_no_busy",  64'(bseen), 64'd0);

    run(0, 500, 0, cyc);
    check("t6_rerun_lat", 64'(cyc),   64'd121);
    check("t6_rerun_min", 64'(min_a), 64'd4);
    check("t6_rerun_cnt", 64'(cnt_a), 64'd24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
